// File: rtl/mac_vec_acc.sv
// Multi-lane multiply-accumulate engine: each beat's LANES products are summed and
// accumulated with saturation over cfg_len beats, result returned via valid/ready.
module mac_vec_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        cfg_len,
  input  logic                        cfg_signed,
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ACC_WIDTH-1:0]        acc_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        ovf,
  output logic                        busy
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + $clog2(LANES);
  localparam int TW = SW + 1;

  localparam logic [TW-1:0] SMAX = {{(TW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [TW-1:0] SMIN = {{(TW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [TW-1:0] UMAX = {{(TW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_e;

  // Clamp a widened accumulator sum; MSB of the result flags a clamp.
  function automatic logic [ACC_WIDTH:0] sat_acc(input logic [TW-1:0] x, input logic is_signed);
    logic [ACC_WIDTH:0] r;
    r = {1'b0, x[ACC_WIDTH-1:0]};
    if (is_signed) begin
      if ($signed(x) > $signed(SMAX))      r = {1'b1, SMAX[ACC_WIDTH-1:0]};
      else if ($signed(x) < $signed(SMIN)) r = {1'b1, SMIN[ACC_WIDTH-1:0]};
    end else if (x > UMAX) begin
      r = {1'b1, UMAX[ACC_WIDTH-1:0]};
    end
    return r;
  endfunction

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   signed_q, signed_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   acc_out_q, acc_out_d;
  logic                   ovf_q, ovf_d;
  logic                   vld_p1_q, vld_p1_d;

  logic signed [PW-1:0]   a_ext [LANES];
  logic signed [PW-1:0]   b_ext [LANES];
  logic signed [PW-1:0]   prod_p1_d [LANES];
  logic signed [PW-1:0]   prod_p1_q [LANES];

  logic [SW-1:0]          lane_sum;
  logic [TW-1:0]          acc_ext, sum_ext, acc_total;
  logic [ACC_WIDTH:0]     sat_res;
  logic                   accept;

  assign in_ready  = (state_q == S_ACCUM) && (cnt_q < len_q);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;

  // Stage 1: per-lane products, operands extended by the latched mode
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_ext[i] = {{DATA_WIDTH{signed_q & a[i*DATA_WIDTH+DATA_WIDTH-1]}}, a[i*DATA_WIDTH +: DATA_WIDTH]};
      b_ext[i] = {{DATA_WIDTH{signed_q & b[i*DATA_WIDTH+DATA_WIDTH-1]}}, b[i*DATA_WIDTH +: DATA_WIDTH]};
      prod_p1_d[i] = a_ext[i] * b_ext[i];
    end
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
  end

  // Stage 2: lane reduction at full width, then saturating accumulate
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(SW-PW){signed_q & prod_p1_q[i][PW-1]}}, prod_p1_q[i]};
    end
    acc_ext   = {{(TW-ACC_WIDTH){signed_q & acc_q[ACC_WIDTH-1]}}, acc_q};
    sum_ext   = {signed_q & lane_sum[SW-1], lane_sum};
    acc_total = acc_ext + sum_ext;
    sat_res   = sat_acc(acc_total, signed_q);
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    ovf_d     = ovf_q;
    vld_p1_d  = accept;

    if (vld_p1_q) begin
      acc_d = sat_res[ACC_WIDTH-1:0];
      ovf_d = ovf_q | sat_res[ACC_WIDTH];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          signed_d  = cfg_signed;
          cnt_d     = '0;
          acc_d     = '0;
          ovf_d     = 1'b0;
          acc_out_d = '0;
          state_d   = (cfg_len == '0) ? S_OUT : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (cnt_q + LEN_WIDTH'(1) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once no product is pending, acc_q already holds the final sum.
        if (!vld_p1_q) begin
          acc_out_d = acc_q;
          state_d   = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      acc_q     <= '0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      ovf_q     <= ovf_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Directed bench for mac_vec_acc: a 32-bit accumulator instance and a 16-bit one
// for saturation, with hand-computed expected results.
module tb_mac_vec_acc;
  localparam int DW = 8;
  localparam int L  = 4;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;
  logic start, start16, in_valid, in_valid16, out_ready, cfg_signed;
  logic [LW-1:0]   cfg_len;
  logic [L*DW-1:0] a, b;

  logic        in_ready, out_valid, ovf, busy;
  logic [31:0] acc_out;
  logic        in_ready16, out_valid16, ovf16, busy16;
  logic [15:0] acc_out16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_vec_acc #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(32), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf), .busy(busy));

  mac_vec_acc #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(16), .LEN_WIDTH(LW)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .a(a), .b(b), .in_valid(in_valid16), .in_ready(in_ready16), .acc_out(acc_out16),
    .out_valid(out_valid16), .out_ready(out_ready), .ovf(ovf16), .busy(busy16));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input bit s16, input logic [LW-1:0] len, input bit sgn);
    cfg_len = len;
    cfg_signed = sgn;
    if (s16) start16 = 1'b1; else start = 1'b1;
    step();
    start = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic beat(input bit s16, input logic [DW-1:0] va, input logic [DW-1:0] vb);
    a = {L{va}};
    b = {L{vb}};
    if (s16) in_valid16 = 1'b1; else in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_valid16 = 1'b0;
  endtask

  task automatic wait_out(input bit s16, output int n);
    n = 0;
    while (((s16 ? out_valid16 : out_valid) !== 1'b1) && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0b exp=0", ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (acc_out !== 32'd0) begin failures++; $display("FAIL rst_acc_out got=%0h exp=0", acc_out); end
    checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL rst_busy16 got=%0b exp=0", busy16); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_unsigned();
    start_job(0, 16'd3, 1'b0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL uns_busy got=%0b exp=1", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL uns_in_ready got=%0b exp=1", in_ready); end
    beat(0, 8'd5, 8'd3);
    beat(0, 8'd2, 8'd2);
    beat(0, 8'd6, 8'd1);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL uns_ready_drop got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL uns_lat0 got=%0b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL uns_lat1 got=%0b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL uns_lat2 got=%0b exp=1", out_valid); end
    checks++; if (acc_out !== 32'd100) begin failures++; $display("FAIL uns_acc got=%0d exp=100", acc_out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL uns_ovf got=%0b exp=0", ovf); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL uns_hs_ovalid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL uns_hs_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_signed();
    int n;
    start_job(0, 16'd2, 1'b1);
    beat(0, 8'hFD, 8'h04);
    beat(0, 8'hFD, 8'h04);
    wait_out(0, n);
    checks++; if (n != 2) begin failures++; $display("FAIL sgn_latency got=%0d exp=2", n); end
    checks++; if (acc_out !== 32'hFFFFFFA0) begin failures++; $display("FAIL sgn_acc got=%0h exp=ffffffa0", acc_out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sgn_ovf got=%0b exp=0", ovf); end
    handshake();
    start_job(0, 16'd2, 1'b0);
    beat(0, 8'hFD, 8'h04);
    beat(0, 8'hFD, 8'h04);
    wait_out(0, n);
    checks++; if (acc_out !== 32'd8096) begin failures++; $display("FAIL uns253_acc got=%0d exp=8096 wait=%0d", acc_out, n); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL uns253_ovf got=%0b exp=0", ovf); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n;
    start_job(0, 16'd3, 1'b0);
    beat(0, 8'd5, 8'd3);
    cfg_len = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_in_ready got=%0b exp=1", in_ready); end
    beat(0, 8'd2, 8'd2);
    step();
    beat(0, 8'd6, 8'd1);
    wait_out(0, n);
    checks++; if (n != 2) begin failures++; $display("FAIL stall_latency got=%0d exp=2", n); end
    checks++; if (acc_out !== 32'd100) begin failures++; $display("FAIL stall_acc got=%0d exp=100", acc_out); end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cfg_len = 16'd0;
      start = (k == 2);
      step();
      start = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%0b exp=1", k, out_valid); end
      checks++; if (acc_out !== 32'd100) begin failures++; $display("FAIL bp_acc cyc=%0d got=%0d exp=100", k, acc_out); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", k, in_ready); end
    end
    out_ready = 1'b1;
    start = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hs_start_ovalid got=%0b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hs_start_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_zero_len();
    start_job(0, 16'd0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zl_out_valid got=%0b exp=1", out_valid); end
    checks++; if (acc_out !== 32'd0) begin failures++; $display("FAIL zl_acc got=%0d exp=0", acc_out); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL zl_ovf got=%0b exp=0", ovf); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL zl_in_ready got=%0b exp=0", in_ready); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL zl_hs got=%0b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    int n;
    start_job(1, 16'd2, 1'b0);
    beat(1, 8'hFF, 8'hFF);
    beat(1, 8'hFF, 8'hFF);
    wait_out(1, n);
    checks++; if (acc_out16 !== 16'hFFFF) begin failures++; $display("FAIL usat_acc got=%0h exp=ffff wait=%0d", acc_out16, n); end
    checks++; if (ovf16 !== 1'b1) begin failures++; $display("FAIL usat_ovf got=%0b exp=1", ovf16); end
    handshake();
    start_job(1, 16'd1, 1'b1);
    beat(1, 8'h80, 8'h80);
    wait_out(1, n);
    checks++; if (acc_out16 !== 16'h7FFF) begin failures++; $display("FAIL ssat_acc got=%0h exp=7fff wait=%0d", acc_out16, n); end
    checks++; if (ovf16 !== 1'b1) begin failures++; $display("FAIL ssat_ovf got=%0b exp=1", ovf16); end
    handshake();
    start_job(1, 16'd1, 1'b0);
    beat(1, 8'd1, 8'd1);
    wait_out(1, n);
    checks++; if (acc_out16 !== 16'd4) begin failures++; $display("FAIL nosat_acc got=%0d exp=4 wait=%0d", acc_out16, n); end
    checks++; if (ovf16 !== 1'b0) begin failures++; $display("FAIL nosat_ovf got=%0b exp=0", ovf16); end
    handshake();
  endtask

  task automatic test_reset_midjob();
    int n;
    start_job(0, 16'd4, 1'b0);
    beat(0, 8'd5, 8'd3);
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (acc_out !== 32'd0 || ovf !== 1'b0) begin failures++; $display("FAIL mid_rst_acc got=%0d/%0b exp=0/0", acc_out, ovf); end
    step();
    rst = 1'b1;
    step();
    start_job(0, 16'd1, 1'b0);
    beat(0, 8'd5, 8'd3);
    wait_out(0, n);
    checks++; if (n != 2) begin failures++; $display("FAIL post_rst_latency got=%0d exp=2", n); end
    checks++; if (acc_out !== 32'd60) begin failures++; $display("FAIL post_rst_acc got=%0d exp=60", acc_out); end
    handshake();
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    start16 = 1'b0;
    in_valid = 1'b0;
    in_valid16 = 1'b0;
    out_ready = 1'b0;
    cfg_signed = 1'b0;
    cfg_len = '0;
    a = '0;
    b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_zero_len();
    test_saturation();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
